// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite slave bridge: response codes,
// write/read FSM state encodings and default bus widths.
package axil_pkg;

    localparam int AXIL_ADDR_W = 20;
    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_read_engine.sv
// Read side of the AXI4-Lite bridge: AR capture, single-cycle rd_en pulse,
// fixed-latency wait on the accelerator read port, and R response.
module axil_read_engine
    import axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = AXIL_ADDR_W,
    parameter int          DATA_WIDTH = AXIL_DATA_W,
    parameter int          RD_LATENCY = 1,
    parameter bit          ADDR_CHECK = 1'b0,
    parameter int unsigned HIGH_ADDR  = 547922
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] HIGH_LIM = ADDR_WIDTH'(HIGH_ADDR);
    localparam logic [2:0]            LAT      = 3'(RD_LATENCY);

    rd_state_t             r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_en;
    logic [2:0]            r_cnt;

    logic w_ar_hs;
    logic w_ar_bad;

    assign w_ar_hs  = i_arvalid & r_arready;
    assign w_ar_bad = ADDR_CHECK && (i_araddr >= HIGH_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        if (w_ar_bad) begin
                            r_rdata  <= '0;
                            r_rresp  <= RESP_SLVERR;
                            r_rvalid <= 1'b1;
                            r_rstate <= R_RESP;
                        end else begin
                            r_rd_addr <= i_araddr;
                            r_rd_en   <= 1'b1;
                            r_rstate  <= R_ISSUE;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    r_rd_en  <= 1'b0;
                    r_cnt    <= 3'd1;
                    r_rstate <= R_WAIT;
                end
                R_WAIT: begin
                    // r_cnt is the number of cycles since the rd_en pulse;
                    // the address stays on o_rd_addr the whole time.
                    if (r_cnt == LAT) begin
                        r_rdata  <= i_rd_data;
                        r_rresp  <= RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                R_RESP: begin
                    if (i_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rresp   = r_rresp;
    assign o_rdata   = r_rdata;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_en   = r_rd_en;

endmodule

// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave to flat accelerator register strobes; write FSM lives here,
// reads go through axil_read_engine. Define AXIL_ADDR_CHECK_EN for SLVERR on
// addresses at or above HIGH_ADDR.
module axil_slave_bridge
    import axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = AXIL_ADDR_W,
    parameter int          DATA_WIDTH = AXIL_DATA_W,
    parameter int          RD_LATENCY = 1,
    parameter int unsigned HIGH_ADDR  = 547922
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   axi_wr_addr,
    output logic [DATA_WIDTH-1:0]   axi_wr_data,
    output logic [DATA_WIDTH/8-1:0] axi_wr_strobe,
    output logic                    axi_wr_en,
    output logic [ADDR_WIDTH-1:0]   axi_rd_addr,
    output logic                    axi_rd_en,
    input  logic [DATA_WIDTH-1:0]   axi_rd_data
);

    localparam int STRB_W = DATA_WIDTH / 8;

`ifdef AXIL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] HIGH_LIM = ADDR_WIDTH'(HIGH_ADDR);

    wr_state_t             r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [STRB_W-1:0]     r_wr_strb;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic                  w_wr_bad;

    // AW and W are tracked separately so either may arrive first.
    assign w_aw_hs       = s_axi_awvalid & r_awready;
    assign w_w_hs        = s_axi_wvalid & r_wready;
    assign w_aw_done     = r_aw_held | w_aw_hs;
    assign w_w_done      = r_w_held | w_w_hs;
    assign w_wr_addr_nxt = w_aw_hs ? s_axi_awaddr : r_wr_addr;
    assign w_wr_bad      = ADDR_CHECK && (w_wr_addr_nxt >= HIGH_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_addr <= s_axi_awaddr;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wr_data <= s_axi_wdata;
                        r_wr_strb <= s_axi_wstrb;
                        r_w_held  <= 1'b1;
                    end
                    r_awready <= !w_aw_done;
                    r_wready  <= !w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        if (w_wr_bad) begin
                            r_bresp  <= RESP_SLVERR;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wr_en  <= 1'b1;
                            r_wstate <= W_EXEC;
                        end
                    end
                end
                W_EXEC: begin
                    r_bresp  <= RESP_OKAY;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    // Readys come back together with the B handshake so the
                    // next AW/W can be taken on the very next cycle.
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign axi_wr_en     = r_wr_en;
    assign axi_wr_addr   = r_wr_addr;
    assign axi_wr_data   = r_wr_data;
    assign axi_wr_strobe = r_wr_strb;

    axil_read_engine #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY),
        .ADDR_CHECK (ADDR_CHECK),
        .HIGH_ADDR  (HIGH_ADDR)
    ) u_read_engine (
        .clk       (clk),
        .rst       (rst),
        .i_araddr  (s_axi_araddr),
        .i_arvalid (s_axi_arvalid),
        .o_arready (s_axi_arready),
        .o_rdata   (s_axi_rdata),
        .o_rresp   (s_axi_rresp),
        .o_rvalid  (s_axi_rvalid),
        .i_rready  (s_axi_rready),
        .o_rd_addr (axi_rd_addr),
        .o_rd_en   (axi_rd_en),
        .i_rd_data (axi_rd_data)
    );

endmodule

// File: tb/tb_axil_slave_bridge.sv
// Bench for axil_slave_bridge: two instances (RD_LATENCY 1 and 3) share one
// master; a word-memory accelerator model and a reference memory judge reads.
`timescale 1ns/1ps
module tb_axil_slave_bridge;

    localparam int AW   = 20;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int HIGH = 547922;
`ifdef AXIL_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;

    logic          awready[2], wready[2], bvalid[2], arready[2], rvalid[2];
    logic          wr_en[2], rd_en[2];
    logic [1:0]    bresp[2], rresp[2];
    logic [DW-1:0] rdata[2], wr_data[2], rd_data[2];
    logic [AW-1:0] wr_addr[2], rd_addr[2];
    logic [SW-1:0] wr_strb[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axil_slave_bridge #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .RD_LATENCY ((g == 0) ? 1 : 3),
            .HIGH_ADDR  (HIGH)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axi_awaddr  (awaddr),
            .s_axi_awvalid (awvalid),
            .s_axi_awready (awready[g]),
            .s_axi_wdata   (wdata),
            .s_axi_wstrb   (wstrb),
            .s_axi_wvalid  (wvalid),
            .s_axi_wready  (wready[g]),
            .s_axi_bresp   (bresp[g]),
            .s_axi_bvalid  (bvalid[g]),
            .s_axi_bready  (bready),
            .s_axi_araddr  (araddr),
            .s_axi_arvalid (arvalid),
            .s_axi_arready (arready[g]),
            .s_axi_rdata   (rdata[g]),
            .s_axi_rresp   (rresp[g]),
            .s_axi_rvalid  (rvalid[g]),
            .s_axi_rready  (rready),
            .axi_wr_addr   (wr_addr[g]),
            .axi_wr_data   (wr_data[g]),
            .axi_wr_strobe (wr_strb[g]),
            .axi_wr_en     (wr_en[g]),
            .axi_rd_addr   (rd_addr[g]),
            .axi_rd_en     (rd_en[g]),
            .axi_rd_data   (rd_data[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    wr_t           wq[$];
    wr_t           mon_e;
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] acc_mem[int];
    int            wr_cnt[2];
    int            rd_cnt[2];
    int            exp_wr = 0;
    int            exp_rd = 0;
    bit [4:0]      hen[2];
    logic [AW-1:0] hadr[2][5];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic bit addr_err(input logic [AW-1:0] a);
        return CHK_EN && (int'(a) >= HIGH);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    function automatic logic [DW-1:0] acc_rd(input logic [AW-1:0] a);
        return acc_mem.exists(int'(a)) ? acc_mem[int'(a)] : '0;
    endfunction

    // Accelerator model: register file written by wr_en, read data valid only
    // exactly RD_LATENCY cycles after rd_en, garbage otherwise.
    always @(negedge clk) begin
        if (wr_en[0] || wr_en[1]) begin
            if (wq.size() > 0) begin
                mon_e = wq[0];
                for (int g = 0; g < 2; g++) begin
                    if (wr_en[g]) begin
                        expect_eq("wr_addr", wr_addr[g], mon_e.a);
                        expect_eq("wr_data", wr_data[g], mon_e.d);
                        expect_eq("wr_strobe", wr_strb[g], mon_e.s);
                    end
                end
                void'(wq.pop_front());
            end
            if (wr_en[0]) acc_mem[int'(wr_addr[0])] = merge(acc_rd(wr_addr[0]), wr_data[0], wr_strb[0]);
        end
        for (int g = 0; g < 2; g++) begin
            wr_cnt[g] += int'(wr_en[g] === 1'b1);
            rd_cnt[g] += int'(rd_en[g] === 1'b1);
            if (rst) begin
                hen[g]     = '0;
                rd_data[g] = 32'hDEAD_BEEF;
            end else begin
                hen[g] = {hen[g][3:0], rd_en[g] === 1'b1};
                for (int k = 4; k > 0; k--) hadr[g][k] = hadr[g][k-1];
                hadr[g][0] = rd_addr[g];
                if (hen[g][lat_of(g)]) begin
                    expect_eq("rd_addr_stable", rd_addr[g], hadr[g][lat_of(g)]);
                    rd_data[g] = acc_rd(hadr[g][lat_of(g)]);
                end else begin
                    rd_data[g] = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int lead, input int bdly);
        bit         err;
        logic [1:0] er;
        int         lat;
        err = addr_err(a);
        er  = err ? 2'b10 : 2'b00;
        if (!err) begin
            wq.push_back('{a: a, d: d, s: s});
            exp_wr++;
            ref_mem[int'(a)] = merge(ref_rd(a), d, s);
        end
        for (int i = 0; i < 20 && !(awready[0] && wready[0]); i++) step();
        expect_eq("wr_ready", {awready[0], wready[0]}, 2'b11);
        if (lead > 0) begin
            wdata = d; wstrb = s; wvalid = 1'b1;
            step();
            wvalid = 1'b0;
            for (int i = 1; i < lead; i++) begin
                for (int g = 0; g < 2; g++) begin
                    expect_eq("wready_low", wready[g], 1'b0);
                    expect_eq("awready_high", awready[g], 1'b1);
                end
                step();
            end
            awaddr = a; awvalid = 1'b1;
            step();
            awvalid = 1'b0;
        end else if (lead < 0) begin
            awaddr = a; awvalid = 1'b1;
            step();
            awvalid = 1'b0;
            for (int i = 1; i < -lead; i++) begin
                for (int g = 0; g < 2; g++) begin
                    expect_eq("awready_low", awready[g], 1'b0);
                    expect_eq("wready_high", wready[g], 1'b1);
                end
                step();
            end
            wdata = d; wstrb = s; wvalid = 1'b1;
            step();
            wvalid = 1'b0;
        end else begin
            awaddr = a; awvalid = 1'b1;
            wdata = d; wstrb = s; wvalid = 1'b1;
            step();
            awvalid = 1'b0; wvalid = 1'b0;
        end
        lat = 1;
        while (!bvalid[0] && lat < 20) begin
            step();
            lat++;
        end
        expect_eq("b_latency", lat, err ? 1 : 2);
        for (int i = 0; i < bdly; i++) begin
            for (int g = 0; g < 2; g++) begin
                expect_eq("bvalid_hold", bvalid[g], 1'b1);
                expect_eq("bresp_hold", bresp[g], er);
                expect_eq("awready_in_resp", awready[g], 1'b0);
            end
            step();
        end
        bready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            expect_eq("bvalid", bvalid[g], 1'b1);
            expect_eq("bresp", bresp[g], er);
        end
        step();
        bready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            expect_eq("bvalid_clear", bvalid[g], 1'b0);
            expect_eq("aw_w_ready_back", {awready[g], wready[g]}, 2'b11);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdly);
        bit            err;
        logic [DW-1:0] ed;
        logic [1:0]    er;
        int            lat[2];
        err = addr_err(a);
        ed  = err ? '0 : ref_rd(a);
        er  = err ? 2'b10 : 2'b00;
        if (!err) exp_rd++;
        for (int i = 0; i < 20 && !(arready[0] && arready[1]); i++) step();
        expect_eq("ar_ready", {arready[0], arready[1]}, 2'b11);
        araddr = a; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        lat = '{99, 99};
        for (int c = 1; c <= 20 && (lat[0] == 99 || lat[1] == 99); c++) begin
            for (int g = 0; g < 2; g++)
                if (rvalid[g] && lat[g] == 99) lat[g] = c;
            if (lat[0] == 99 || lat[1] == 99) step();
        end
        for (int g = 0; g < 2; g++)
            expect_eq("r_latency", lat[g], err ? 1 : 2 + lat_of(g));
        for (int i = 0; i < rdly; i++) begin
            for (int g = 0; g < 2; g++) begin
                expect_eq("rvalid_hold", rvalid[g], 1'b1);
                expect_eq("rdata_hold", rdata[g], ed);
                expect_eq("arready_in_resp", arready[g], 1'b0);
            end
            step();
        end
        rready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            expect_eq("rvalid", rvalid[g], 1'b1);
            expect_eq("rdata", rdata[g], ed);
            expect_eq("rresp", rresp[g], er);
        end
        step();
        rready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            expect_eq("rvalid_clear", rvalid[g], 1'b0);
            expect_eq("arready_back", arready[g], 1'b1);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            expect_eq("rst_readys", {awready[g], wready[g], arready[g]}, 3'b000);
            expect_eq("rst_valids", {bvalid[g], rvalid[g], wr_en[g], rd_en[g]}, 4'b0000);
            expect_eq("rst_resps", {bresp[g], rresp[g]}, 4'b0000);
            expect_eq("rst_rdata", rdata[g], '0);
            expect_eq("rst_wr_bus", {wr_addr[g], wr_data[g], wr_strb[g]}, '0);
            expect_eq("rst_rd_addr", rd_addr[g], '0);
        end
        rst = 1'b0;

        do_write(20'h6_0808, 32'h0000_0001, 4'hF, 0, 0);
        do_write(20'h6_080C, 32'h1234_5678, 4'h3, 3, 0);
        do_write(20'h6_0804, 32'h0000_0001, 4'hF, -2, 0);
        do_read(20'h6_0804, 0);
        do_write(20'h6_0810, 32'hCAFE_F00D, 4'hF, 0, 5);
        do_read(20'h6_0810, 5);
        do_read(20'h6_080C, 1);

        fork
            do_write(20'h6_0000, 32'hA5A5_0001, 4'hF, 0, 0);
            do_read(20'h6_0004, 0);
        join

        // Reset while both read engines sit in R_WAIT.
        for (int i = 0; i < 20 && !(arready[0] && arready[1]); i++) step();
        araddr = 20'h6_0810; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        exp_rd++;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            expect_eq("midrst_readys", {awready[g], wready[g], arready[g]}, 3'b000);
            expect_eq("midrst_valids", {bvalid[g], rvalid[g], wr_en[g], rd_en[g]}, 4'b0000);
            expect_eq("midrst_rd_addr", rd_addr[g], '0);
        end
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < 2; g++) expect_eq("rvalid_after_rst", rvalid[g], 1'b0);
            step();
        end
        for (int g = 0; g < 2; g++) expect_eq("arready_after_rst", arready[g], 1'b1);

        do_write(20'h8_5C54, 32'h0000_0077, 4'hF, 0, 1);
        do_read(20'h8_5C54, 1);
        do_write(20'h8_5C51, 32'h0BAD_CAFE, 4'hF, 1, 0);
        do_read(20'h8_5C51, 0);
        do_read(20'h8_5C52, 0);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            a  = 20'h6_0000 + 20'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 20'(HIGH + $urandom_range(0, 15));
            if (op == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                         $urandom_range(0, 3));
            end else if (op == 1) begin
                do_read(a, $urandom_range(0, 3));
            end else begin
                fork
                    do_write(a, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 4)) - 2,
                             $urandom_range(0, 3));
                    do_read(a ^ 20'h4, $urandom_range(0, 3));
                join
            end
        end

        repeat (6) step();
        for (int g = 0; g < 2; g++) begin
            expect_eq("wr_en_count", wr_cnt[g], exp_wr);
            expect_eq("rd_en_count", rd_cnt[g], exp_rd);
        end
        expect_eq("wr_queue_left", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
